// File: rtl/conversionFunctions.sv
// Binary/Gray pointer conversion helpers for async_fifo.
// Functions take up to 32-bit values; callers truncate to PNTR_WIDTH+1 bits.
package conversionFunctions;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for async_fifo: one write port, one asynchronous read port.
// Contents are not reset.
module fifo_mem #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_LEN-1:0] data_out
);

  logic [DATA_LEN-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= data_in;
  end

  assign data_out = mem[read_addr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FWFT FIFO with Gray-coded pointers and combinational flags.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add overflow/underflow pulse outputs.
module async_fifo
  import conversionFunctions::*;
#(
  parameter int DATA_LEN   = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic                read_en,
  input  logic [DATA_LEN-1:0] data_in,
  output logic [DATA_LEN-1:0] data_out,
  output logic                fifo_full,
  output logic                fifo_empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int PW = PNTR_WIDTH + 1;

  logic [PW-1:0] write_pointer, read_pointer;
  logic [PW-1:0] write_gray, read_gray;
  logic [PW-1:0] write_next, read_next;
  logic          wr_ok, rd_ok;

  assign fifo_empty = (write_gray == read_gray);
  // Full: one lap ahead, which in Gray code flips the top two bits.
  assign fifo_full  = (write_gray ==
                       {~read_gray[PW-1:PW-2], read_gray[PW-3:0]});

  assign wr_ok      = write_en && !fifo_full;
  assign rd_ok      = read_en && !fifo_empty;
  assign write_next = write_pointer + 1'b1;
  assign read_next  = read_pointer + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      write_gray    <= '0;
      read_gray     <= '0;
    end else begin
      if (wr_ok) begin
        write_pointer <= write_next;
        write_gray    <= PW'(bin2gray(ptr_t'(write_next)));
      end
      if (rd_ok) begin
        read_pointer <= read_next;
        read_gray    <= PW'(bin2gray(ptr_t'(read_next)));
      end
    end
  end

  fifo_mem #(
    .DATA_LEN (DATA_LEN),
    .ADDR_W   (PNTR_WIDTH)
  ) u_mem (
    .clk        (clk),
    .write_en   (wr_ok && !reset),
    .write_addr (write_pointer[PNTR_WIDTH-1:0]),
    .data_in    (data_in),
    .read_addr  (read_pointer[PNTR_WIDTH-1:0]),
    .data_out   (data_out)
  );

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_en && fifo_full;
      underflow <= read_en && fifo_empty;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo against a queue model.
// Covers Gray helpers, overflow, empty reads, wrap, simultaneous access, reset.
module tb_async_fifo;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic        read_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int vecs = 0;
  int errs = 0;

  logic [15:0] q[$];
  logic [9:0]  occ;

  always #5 clk = ~clk;

  async_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .read_en    (read_en),
    .data_in    (data_in),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  assign occ = dut.write_pointer - dut.read_pointer;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; predicts and checks against the model.
  task automatic cycle(input logic we, input logic re,
                       input logic [15:0] d, output bit wacc);
    bit racc;
    write_en = we;
    read_en  = re;
    data_in  = d;
    #1;
    wacc = we && (q.size() < DEPTH);
    racc = re && (q.size() > 0);
    if (racc) check("head", 32'(data_out), 32'(q[0]));
    @(posedge clk);
    #1;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
    write_en = 1'b0;
    read_en  = 1'b0;
    check("empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("occ", 32'(occ), 32'(q.size()));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(we && !wacc));
    check("underflow", 32'(underflow), 32'(re && !racc));
`endif
  endtask

  task automatic do_reset(input logic we, input logic re);
    reset    = 1'b1;
    write_en = we;
    read_en  = re;
    data_in  = 16'h5A5A;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    q.delete();
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_wptr", 32'(dut.write_pointer), 32'd0);
    check("rst_rptr", 32'(dut.read_pointer), 32'd0);
    check("rst_wgray", 32'(dut.write_gray), 32'd0);
    check("rst_rgray", 32'(dut.read_gray), 32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int vals[10] = '{0, 10, 51, 511, 1, 45, 100, 101, 250, 513};
    bit wacc;
    int wn;
    int cyc;
    logic [9:0] g;
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    foreach (vals[i]) begin
      g = 10'(conversionFunctions::bin2gray(32'(vals[i])));
      check("gray_rt",
            32'(10'(conversionFunctions::gray2bin(32'(g)))),
            32'(vals[i]));
    end
    check("gray_511",
          32'(10'(conversionFunctions::bin2gray(32'd511))),
          32'(10'b0100000000));

    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 16'h0, wacc);
      check("erd_rptr", 32'(dut.read_pointer), 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 16'(i), wacc);
    check("ovf_full", 32'(fifo_full), 32'd1);
    cycle(1'b1, 1'b0, 16'hDEAD, wacc);
    check("ovf_wptr", 32'(dut.write_pointer), 32'd512);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("ovf_data", 32'(data_out), 32'(i));
      cycle(1'b0, 1'b1, 16'h0, wacc);
    end
    check("ovf_empty", 32'(fifo_empty), 32'd1);

    wn  = 0;
    cyc = 0;
    while (wn < 1500 && cyc < 8000) begin
      cycle(1'b1, (cyc % 4) != 3, 16'(wn + 16'h1000), wacc);
      if (wacc) wn++;
      cyc++;
    end
    check("wrap_count", 32'(wn), 32'd1500);
    while (q.size() > 0 && cyc < 10000) begin
      cycle(1'b0, 1'b1, 16'h0, wacc);
      cyc++;
    end
    check("wrap_drained", 32'(fifo_empty), 32'd1);

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'(16'h2000 + i), wacc);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 16'(16'h3000 + i), wacc);
      check("sim_occ", 32'(occ), 32'd5);
    end
    while (q.size() < DEPTH) cycle(1'b1, 1'b0, 16'(q.size()), wacc);
    check("sim_full", 32'(fifo_full), 32'd1);
    cycle(1'b1, 1'b1, 16'hBEEF, wacc);
    check("sim_occ511", 32'(occ), 32'd511);
    check("sim_nofull", 32'(fifo_full), 32'd0);

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 16'(i), wacc);
    check("mid_occ", 32'(occ), 32'd300);
    do_reset(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
